// File: rtl/nec_div_seq.sv
// rtl/nec_div_seq.sv - NEC DIV/DIVU sequencer: builds divider operands, range-checks the result, returns it to the EU
// Optional macro NEC_DIV_TIMING_EN pads res_valid to fixed per-op ce-cycle counts.
module nec_div_seq
`ifdef NEC_DIV_TIMING_EN
#(
    parameter int CYC_DIVU_B = 19,
    parameter int CYC_DIVU_W = 25,
    parameter int CYC_DIV_B  = 29,
    parameter int CYC_DIV_W  = 38
)
`endif
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_signed,
    input  logic        req_word,
    input  logic [15:0] req_aw,
    input  logic [15:0] req_dw,
    input  logic [15:0] req_src,
    input  logic        abort,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_lo,
    output logic [15:0] res_hi,
    output logic        div_err,
    output logic        div_start,
    output logic        div_wide,
    output logic [32:0] div_a,
    output logic [32:0] div_b,
    input  logic        div_done,
    input  logic        div_overflow,
    input  logic        div_dbz,
    input  logic [15:0] div_quot,
    input  logic [15:0] div_rem
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic        signed_q, signed_d;
    logic        word_q, word_d;
    logic [32:0] div_a_q, div_a_d;
    logic [32:0] div_b_q, div_b_d;
    logic [15:0] res_lo_q, res_lo_d;
    logic [15:0] res_hi_q, res_hi_d;
    logic        res_valid_q, res_valid_d;
    logic        div_err_q, div_err_d;

    logic        accept;
    logic        count_ok;
    logic        neg;
    logic        quot_nz;
    logic        range_fail;
    logic        err;

    assign accept = ce & ~abort & (state_q == S_IDLE) & req_valid;

`ifdef NEC_DIV_TIMING_EN
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cyc_sel;
    logic [8:0] cnt_inc;

    // count_ok looks at the value the counter takes on this edge
    always_comb begin
        case ({signed_q, word_q})
            2'b00:   cyc_sel = 8'(CYC_DIVU_B);
            2'b01:   cyc_sel = 8'(CYC_DIVU_W);
            2'b10:   cyc_sel = 8'(CYC_DIV_B);
            default: cyc_sel = 8'(CYC_DIV_W);
        endcase
        cnt_inc  = {1'b0, cnt_q} + 9'd1;
        count_ok = (cnt_inc >= {1'b0, cyc_sel});
        cnt_d    = cnt_q;
        if (ce) begin
            if (abort || accept) begin
                cnt_d = 8'h00;
            end else if (cnt_q != 8'hFF) begin
                cnt_d = cnt_inc[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 8'h00;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign count_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ce) begin
            if (abort) begin
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE:   if (req_valid) state_d = S_LAUNCH;
                    S_LAUNCH: state_d = S_WAIT;
                    S_WAIT:   if (div_done) state_d = S_HOLD;
                    S_HOLD:   if (res_valid_q && res_ready) state_d = S_IDLE;
                    default:  state_d = S_IDLE;
                endcase
            end
        end
    end

    // Range checks catch quotients the divider accepts but DIV/DIVU cannot write back
    always_comb begin
        neg     = signed_q & (div_a_q[32] ^ div_b_q[32]);
        quot_nz = (div_quot != 16'h0000);
        if (word_q) begin
            range_fail = signed_q & quot_nz & (div_quot[15] != neg);
        end else if (signed_q) begin
            range_fail = (div_quot[15:8] != {8{div_quot[7]}}) | (quot_nz & (div_quot[7] != neg));
        end else begin
            range_fail = (div_quot[15:8] != 8'h00);
        end
        err = div_dbz | div_overflow | range_fail;
    end

    always_comb begin
        signed_d    = signed_q;
        word_d      = word_q;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        res_lo_d    = res_lo_q;
        res_hi_d    = res_hi_q;
        res_valid_d = res_valid_q;
        div_err_d   = div_err_q;
        if (ce) begin
            if (abort) begin
                res_valid_d = 1'b0;
                div_err_d   = 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (req_valid) begin
                            signed_d = req_signed;
                            word_d   = req_word;
                            if (req_word) begin
                                div_a_d = {req_signed & req_dw[15], req_dw, req_aw};
                                div_b_d = {{17{req_signed & req_src[15]}}, req_src};
                            end else begin
                                div_a_d = {{17{req_signed & req_aw[15]}}, req_aw};
                                div_b_d = {{25{req_signed & req_src[7]}}, req_src[7:0]};
                            end
                        end
                    end
                    S_WAIT: begin
                        if (div_done) begin
                            div_err_d   = err;
                            res_valid_d = count_ok;
                            if (err) begin
                                res_lo_d = 16'h0000;
                                res_hi_d = 16'h0000;
                            end else if (word_q) begin
                                res_lo_d = div_quot;
                                res_hi_d = div_rem;
                            end else begin
                                res_lo_d = {div_rem[7:0], div_quot[7:0]};
                                res_hi_d = 16'h0000;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (res_valid_q && res_ready) begin
                            res_valid_d = 1'b0;
                            div_err_d   = 1'b0;
                        end else if (!res_valid_q && count_ok) begin
                            res_valid_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            signed_q    <= 1'b0;
            word_q      <= 1'b0;
            div_a_q     <= 33'h0;
            div_b_q     <= 33'h0;
            res_lo_q    <= 16'h0000;
            res_hi_q    <= 16'h0000;
            res_valid_q <= 1'b0;
            div_err_q   <= 1'b0;
        end else begin
            signed_q    <= signed_d;
            word_q      <= word_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            res_lo_q    <= res_lo_d;
            res_hi_q    <= res_hi_d;
            res_valid_q <= res_valid_d;
            div_err_q   <= div_err_d;
        end
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        div_start = (state_q == S_LAUNCH);
        res_valid = res_valid_q;
        div_err   = div_err_q;
        res_lo    = res_lo_q;
        res_hi    = res_hi_q;
        div_wide  = word_q;
        div_a     = div_a_q;
        div_b     = div_b_q;
    end

endmodule

// File: tb/tb_nec_div_seq.sv
// tb/tb_nec_div_seq.sv - self-checking bench for nec_div_seq with a behavioural divider stub
`timescale 1ns/1ps
module tb_nec_div_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_signed = 1'b0;
    logic        req_word = 1'b0;
    logic [15:0] req_aw = '0, req_dw = '0, req_src = '0;
    logic        abort = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_lo, res_hi;
    logic        div_err, div_start, div_wide;
    logic [32:0] div_a, div_b;
    logic        div_done;
    logic        div_overflow, div_dbz;
    logic [15:0] div_quot, div_rem;

    int n_tests = 0;
    int n_fail = 0;
    int ce_edges = 0;
    int rv_rises = 0;
    logic rv_prev = 1'b0;
    bit ce_rand = 1'b0;
    int stub_lat = 2;
    int t_acc = 0;

    logic        stub_busy;
    int          stub_cnt;
    logic [33:0] stub_res;

    nec_div_seq dut (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed), .req_word(req_word),
        .req_aw(req_aw), .req_dw(req_dw), .req_src(req_src), .abort(abort),
        .res_valid(res_valid), .res_ready(res_ready), .res_lo(res_lo), .res_hi(res_hi),
        .div_err(div_err), .div_start(div_start), .div_wide(div_wide), .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_overflow(div_overflow), .div_dbz(div_dbz),
        .div_quot(div_quot), .div_rem(div_rem)
    );

    always #5 clk = ~clk;

    // Divider stub: magnitude divide on sign-flagged operands, done stub_lat ce cycles after start
    function automatic logic [33:0] stub_eval(input logic [32:0] a, input logic [32:0] b);
        longint sa, sb, ma, mb, qm, rm, qv, rv;
        logic ovf, dbz;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        dbz = (mb == 0);
        qv = 0; rv = 0; ovf = 1'b0;
        if (!dbz) begin
            qm  = ma / mb;
            rm  = ma % mb;
            ovf = (qm > 65535);
            qv  = ((sa < 0) != (sb < 0)) ? -qm : qm;
            rv  = (sa < 0) ? -rm : rm;
        end
        return {ovf, dbz, qv[15:0], rv[15:0]};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stub_busy <= 1'b0;
            stub_cnt  <= 0;
            div_done  <= 1'b0;
            stub_res  <= '0;
        end else if (ce) begin
            div_done <= 1'b0;
            if (div_start) begin
                stub_busy <= 1'b1;
                stub_cnt  <= stub_lat;
                stub_res  <= stub_eval(div_a, div_b);
            end else if (stub_busy) begin
                if (stub_cnt <= 1) begin
                    stub_busy <= 1'b0;
                    div_done  <= 1'b1;
                end else begin
                    stub_cnt <= stub_cnt - 1;
                end
            end
        end
    end
    assign {div_overflow, div_dbz, div_quot, div_rem} = stub_res;

    always @(posedge clk) begin
        if (ce && reset_n) ce_edges <= ce_edges + 1;
        rv_prev <= res_valid;
        if (res_valid && !rv_prev) rv_rises <= rv_rises + 1;
    end

    // Reference: x86-style DIV/DIVU on plain integers; returns {err, lo, hi}
    function automatic logic [32:0] ref_div(input bit s, input bit w, input logic [15:0] aw,
                                            input logic [15:0] dw, input logic [15:0] src);
        longint n, d, q, r;
        logic [7:0] s8;
        bit e;
        s8 = src[7:0];
        if (w) begin
            n = s ? longint'($signed({dw, aw})) : longint'({dw, aw});
            d = s ? longint'($signed(src)) : longint'(src);
        end else begin
            n = s ? longint'($signed(aw)) : longint'(aw);
            d = s ? longint'($signed(s8)) : longint'(s8);
        end
        if (d == 0) return {1'b1, 32'h0};
        q = n / d;
        r = n % d;
        if (w) e = s ? (q < -32768 || q > 32767) : (q > 65535);
        else   e = s ? (q < -128 || q > 127) : (q > 255);
        if (e) return {1'b1, 32'h0};
        if (w) return {1'b0, q[15:0], r[15:0]};
        return {1'b0, r[7:0], q[7:0], 16'h0000};
    endfunction

    function automatic int exp_lat(input bit s, input bit w, input int lat);
`ifdef NEC_DIV_TIMING_EN
        return s ? (w ? 38 : 29) : (w ? 25 : 19);
`else
        return lat + 2;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        ce = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic issue(input bit s, input bit w, input logic [15:0] aw, input logic [15:0] dw,
                         input logic [15:0] src, input int lat);
        int n = 0;
        stub_lat = lat;
        req_signed = s; req_word = w; req_aw = aw; req_dw = dw; req_src = src;
        req_valid = 1'b1;
        while (!(req_ready && ce) && n < 100) begin step(); n++; end
        chk("accept_bound", 64'(n < 100), 64'd1);
        step();
        t_acc = ce_edges;
        req_valid = 1'b0;
    endtask

    task automatic finish(input string tag, input logic [15:0] elo, input logic [15:0] ehi,
                          input bit eerr, input int lat, input bit s, input bit w, input int hold);
        int n = 0;
        while (!res_valid && n < 400) begin step(); n++; end
        chk({tag, "_bound"}, 64'(n < 400), 64'd1);
        chk({tag, "_lat"}, 64'(ce_edges - t_acc), 64'(exp_lat(s, w, lat)));
        chk({tag, "_lo"}, res_lo, elo);
        chk({tag, "_hi"}, res_hi, ehi);
        chk({tag, "_err"}, div_err, eerr);
        if (hold > 0) begin
            ce_rand = 1'b1;
            for (int i = 0; i < hold; i++) begin
                step();
                chk({tag, "_hold"}, {req_ready, res_valid, div_err, res_lo, res_hi},
                    {1'b0, 1'b1, eerr, elo, ehi});
            end
            ce_rand = 1'b0;
        end
        res_ready = 1'b1;
        n = 0;
        while (!ce && n < 50) begin step(); n++; end
        step();
        res_ready = 1'b0;
        chk({tag, "_release"}, {res_valid, req_ready}, 2'b01);
    endtask

    initial begin
        logic [32:0] r;
        bit s, w;
        logic [15:0] aw, dw, src;
        int lat, rv0;

        repeat (3) step();
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_flags", {res_valid, div_err, div_start, div_wide}, 4'b0000);
        chk("rst_res", {res_lo, res_hi}, 32'h0);
        chk("rst_a", div_a, 33'h0);
        chk("rst_b", div_b, 33'h0);
        reset_n = 1'b1;
        step();

        issue(1'b0, 1'b1, 16'h0000, 16'h0001, 16'h0003, 4);
        finish("divu_w", 16'h5555, 16'h0001, 1'b0, 4, 1'b0, 1'b1, 0);

        issue(1'b1, 1'b0, 16'hFF9C, 16'h0000, 16'h0007, 3);
        chk("div_b8_opa", div_a, 33'h1_FFFF_FF9C);
        chk("div_b8_opb", div_b, 33'h0_0000_0007);
        chk("div_b8_start", {div_start, div_wide}, 2'b10);
        finish("div_b8", 16'hFEF2, 16'h0000, 1'b0, 3, 1'b1, 1'b0, 0);

        issue(1'b1, 1'b1, 16'h8000, 16'h0000, 16'h0001, 5);
        finish("div_w_ovf", 16'h0000, 16'h0000, 1'b1, 5, 1'b1, 1'b1, 0);

        issue(1'b1, 1'b1, 16'h8000, 16'h0000, 16'hFFFF, 2);
        chk("div_w_m1_opb", div_b, 33'h1_FFFF_FFFF);
        finish("div_w_m1", 16'h8000, 16'h0000, 1'b0, 2, 1'b1, 1'b1, 0);

        issue(1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0000, 1);
        finish("divu_b_dbz", 16'h0000, 16'h0000, 1'b1, 1, 1'b0, 1'b0, 0);

        issue(1'b0, 1'b0, 16'h1000, 16'h0000, 16'h0010, 6);
        finish("divu_b_ovf", 16'h0000, 16'h0000, 1'b1, 6, 1'b0, 1'b0, 0);

        issue(1'b0, 1'b1, 16'd100, 16'h0000, 16'd7, 3);
        finish("hold", 16'd14, 16'd2, 1'b0, 3, 1'b0, 1'b1, 10);

        // Abort in WAIT; the stale done lands while idle, coinciding with the next accept
        rv0 = rv_rises;
        issue(1'b0, 1'b1, 16'd1000, 16'h0000, 16'd7, 3);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_idle", {req_ready, res_valid, div_start}, 3'b100);
        step();
        step();
        chk("abort_stale", res_valid, 1'b0);
        issue(1'b0, 1'b1, 16'd100, 16'h0000, 16'd7, 2);
        finish("abort_new", 16'd14, 16'd2, 1'b0, 2, 1'b0, 1'b1, 0);
        step();
        chk("abort_single", 64'(rv_rises - rv0), 64'd1);

        for (int i = 0; i < 40; i++) begin
            s   = 1'($urandom_range(0, 1));
            w   = 1'($urandom_range(0, 1));
            aw  = 16'($urandom);
            case ($urandom_range(0, 2))
                0:       dw = 16'($urandom);
                1:       dw = {16{aw[15]}};
                default: dw = 16'($urandom_range(0, 7));
            endcase
            src = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            lat = $urandom_range(1, 8);
            ce_rand = (i % 2) == 1;
            r = ref_div(s, w, aw, dw, src);
            issue(s, w, aw, dw, src, lat);
            finish("rand", r[31:16], r[15:0], r[32], lat, s, w, 0);
        end
        ce_rand = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nec_div_seq.md
Name: nec_div_seq

Overview:
- Execution-unit sequencer for the NEC DIV/DIVU instructions.
- Takes a register-level divide request (AW/DW or AW plus an 8/16-bit divisor) and builds the 33-bit sign-flagged operands for the serial divider.
- Launches the divider, waits for its done pulse, applies signed-range and byte-mode overflow checks, then returns packed register results or a divide-error trap request to the EU.
- Sits directly upstream of the divider (drives it) and consumes its result.

Parameters:
- CYC_DIVU_B, 19, total ce-cycles from accept to res_valid for DIVU r8 (timing feature only)
- CYC_DIVU_W, 25, same for DIVU r16
- CYC_DIV_B, 29, same for DIV r8
- CYC_DIV_W, 38, same for DIV r16

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; all state advances only when high
- req_valid  in  1  divide request
- req_ready  out  1  high in IDLE only
- req_signed  in  1  1=DIV, 0=DIVU
- req_word  in  1  1=16-bit divisor (DW:AW / src), 0=8-bit (AW / src8)
- req_aw  in  16  AW register value
- req_dw  in  16  DW register value
- req_src  in  16  divisor; low 8 bits used when req_word=0
- abort  in  1  pipeline flush; cancels any operation
- res_valid  out  1  result/trap available, held until res_ready
- res_ready  in  1  EU accepts result
- res_lo  out  16  word: quotient (to AW); byte: {rem8, quot8} (AH, AL)
- res_hi  out  16  word: remainder (to DW); byte: 0
- div_err  out  1  with res_valid: raise INT 0, no register writeback
- div_start  out  1  one-ce-cycle start pulse to divider
- div_wide  out  1  = latched req_word
- div_a  out  33  dividend, bit32 = sign flag
- div_b  out  33  divisor, bit32 = sign flag
- div_done  in  1  divider completion pulse
- div_overflow  in  1  divider magnitude overflow
- div_dbz  in  1  divider divide-by-zero
- div_quot  in  16  signed-corrected quotient
- div_rem  in  16  signed-corrected remainder

Behaviour:
- Reset (async, reset_n low): state IDLE; req_ready=1; res_valid, div_err, div_start=0; res_lo/res_hi, div_a, div_b, div_wide=0.
- FSM states: IDLE, LAUNCH, WAIT, HOLD.
- IDLE: on ce with req_valid, latch the operands and go to LAUNCH. Operand formation:
  - word signed: div_a = sign-extend {dw,aw} to 33 bits; div_b = sign-extend src.
  - word unsigned: zero-extend both.
  - byte: div_a from aw (16 bits), div_b from src[7:0]; sign- or zero-extended per req_signed.
- LAUNCH: div_start=1 for exactly one ce cycle, then go to WAIT.
- WAIT: div_done is ignored in the LAUNCH cycle. On the first ce cycle with div_done=1, evaluate err = dbz | overflow | range_fail:
  - neg = signed & (a sign ^ b sign).
  - word signed: range_fail = quot≠0 & quot[15]≠neg.
  - byte: range_fail = quot[15:8] ≠ {8{quot[7]}} for signed, quot[15:8]≠0 for unsigned, plus the quot≠0 & quot[7]≠neg rule for signed.
  - Register results, set res_valid, go to HOLD.
- HOLD: outputs stable. On ce & res_ready, clear res_valid and go to IDLE; req_ready returns high on the next cycle. No back-to-back accept in the same cycle.
- On err: div_err=1, res_lo=res_hi=0.
- abort (ce high), any state: go to IDLE, drop res_valid and div_start. A late div_done from a cancelled op is ignored in IDLE. A new start reinitialises the divider.
- abort wins over a same-cycle req_valid, div_done or res_ready.
- ce low freezes everything, including div_start being held.
- Minimum latency: accept→res_valid = divider latency + 2 ce cycles.

Optional Feature:
- Macro NEC_DIV_TIMING_EN.
- Defined:
  - An 8-bit counter is cleared on accept and increments per ce cycle.
  - The result is held internally; res_valid asserts only when the counter ≥ the CYC_* value for the op and the divider has finished.
  - dbz/err results obey the same count.
  - abort clears the counter.
- Undefined: res_valid asserts as soon as the result is registered; the counter logic is absent.

Test Plan:
- DIVU word: dw=0x0001, aw=0x0000, src=0x0003 -> res_lo=0x5555, res_hi=0x0001, div_err=0.
- DIV byte: aw=0xFF9C (-100), src=0x0007 -> res_lo=0xFEF2 (AH=-2, AL=-14), div_err=0.
- Signed overflow: DIV word, dw:aw=0x00008000, src=1 -> div_err=1, res_lo=res_hi=0. With src=0xFFFF, same dividend -> res_lo=0x8000, div_err=0.
- Divide by zero: DIVU byte, aw=0x1234, src=0x0000 -> div_err=1; byte overflow DIVU aw=0x1000, src=0x10 -> div_err=1.
- Abort during WAIT, then a new request DIVU word 100/7 issued two cycles later -> single res_valid with res_lo=14, res_hi=2; the stale done produces no result.
- res_ready held low 10 cycles, with ce toggling -> outputs stable, req_ready=0. With NEC_DIV_TIMING_EN: DIV r16 res_valid exactly 38 ce cycles after accept.
